// File: rtl/serial_acc_adder_pkg.sv
// rtl/serial_acc_adder_pkg.sv - shared controller types for the bit-serial accumulator
package serial_acc_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PAGE_ADDR_WIDTH = 8;

endpackage

// File: rtl/serial_acc_adder_if.sv
// rtl/serial_acc_adder_if.sv - control/data bundle between controller and serial accumulator
interface serial_acc_adder_if
  import serial_acc_adder_pkg::*;
#(
  parameter int WIDTH = PAGE_ADDR_WIDTH
);

  logic             i_CEN_n;
  logic             i_LOAD;
  logic [WIDTH-1:0] i_LOAD_D;
  logic             i_START;
  logic             i_SUB;
  logic             i_SER_B;
  logic             o_BUSY;
  logic             o_DONE;
  logic [WIDTH-1:0] o_SUM;
  logic             o_COUT;
  logic             o_ZERO;

  modport master (
    output i_CEN_n, i_LOAD, i_LOAD_D, i_START, i_SUB, i_SER_B,
    input  o_BUSY, o_DONE, o_SUM, o_COUT, o_ZERO
  );

  modport slave (
    input  i_CEN_n, i_LOAD, i_LOAD_D, i_START, i_SUB, i_SER_B,
    output o_BUSY, o_DONE, o_SUM, o_COUT, o_ZERO
  );

endinterface

// File: rtl/serial_acc_adder_fa.sv
// rtl/serial_acc_adder_fa.sv - single-bit full-adder primitive
module serial_acc_adder_fa (
  input  logic i_A,
  input  logic i_B,
  input  logic i_CIN,
  output logic o_S,
  output logic o_COUT
);

  assign o_S    = i_A ^ i_B ^ i_CIN;
  assign o_COUT = (i_A & i_B) | (i_CIN & (i_A ^ i_B));

endmodule

// File: rtl/serial_acc_adder.sv
// rtl/serial_acc_adder.sv - bit-serial add/subtract accumulator, operand LSB first
module serial_acc_adder
  import serial_acc_adder_pkg::*;
#(
  parameter int WIDTH = PAGE_ADDR_WIDTH
)
(
  input  logic              i_EMUCLK,
  input  logic              i_MRST_n,
  serial_acc_adder_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             fa_s;
  logic             fa_cout;

  // Subtract is acc + ~B + 1: operand bits are inverted and carry is seeded with 1.
  serial_acc_adder_fa u_fa (
    .i_A    (acc_q[0]),
    .i_B    (bus.i_SER_B ^ sub_q),
    .i_CIN  (carry_q),
    .o_S    (fa_s),
    .o_COUT (fa_cout)
  );

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    if (!bus.i_CEN_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_LOAD) begin
            acc_d   = bus.i_LOAD_D;
            carry_d = 1'b0;
          end else if (bus.i_START) begin
            sub_d   = bus.i_SUB;
            carry_d = bus.i_SUB;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d   = {fa_s, acc_q[WIDTH-1:1]};
          carry_d = fa_cout;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.o_BUSY = (state_q == RUN);
  assign bus.o_DONE = (state_q == DONE);
  assign bus.o_SUM  = acc_q;
  assign bus.o_COUT = carry_q;
  assign bus.o_ZERO = (acc_q == '0);

endmodule

// File: tb/tb_serial_acc_adder.sv
// tb/tb_serial_acc_adder.sv - randomized self-checking bench for serial_acc_adder
module tb_serial_acc_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  serial_acc_adder_if #(.WIDTH(W)) bus ();

  serial_acc_adder #(.WIDTH(W)) dut (
    .i_EMUCLK (clk),
    .i_MRST_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_CEN_n  = 1'b0;
    bus.i_LOAD   = 1'b0;
    bus.i_LOAD_D = '0;
    bus.i_START  = 1'b0;
    bus.i_SUB    = 1'b0;
    bus.i_SER_B  = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] val);
    @(negedge clk);
    bus.i_CEN_n  = 1'b0;
    bus.i_LOAD   = 1'b1;
    bus.i_LOAD_D = val;
    @(negedge clk);
    bus.i_LOAD   = 1'b0;
    check("load_sum", 32'(bus.o_SUM), 32'(val));
  endtask

  // Loads a, then runs a +/- b with nstall disabled cycles spread over the run;
  // optionally holds START high through the run to show it is ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int nstall, input logic hold_start);
    logic [W:0]   wide;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    int           n;
    int           edges;
    int           stalls;
    if (sub) begin
      exp_sum  = a - b;
      exp_cout = (a >= b);
    end else begin
      wide     = {1'b0, a} + {1'b0, b};
      exp_sum  = wide[W-1:0];
      exp_cout = wide[W];
    end
    do_load(a);
    bus.i_START = 1'b1;
    bus.i_SUB   = sub;
    @(negedge clk);
    bus.i_START = hold_start;
    bus.i_SUB   = $urandom_range(0, 1);
    check("busy_run", 32'(bus.o_BUSY), 32'd1);
    n      = 0;
    edges  = 0;
    stalls = nstall;
    while (n < W) begin
      if (stalls > 0 && n >= 2 && ($urandom_range(0, 1) == 1 || n == W - 1)) begin
        bus.i_CEN_n = 1'b1;
        bus.i_SER_B = $urandom_range(0, 1);
        stalls--;
      end else begin
        bus.i_CEN_n = 1'b0;
        bus.i_SER_B = b[n];
        n++;
      end
      @(negedge clk);
      edges++;
      if (edges == W + nstall - 1) check("not_done_yet", 32'(bus.o_DONE), 32'd0);
    end
    bus.i_CEN_n = 1'b0;
    bus.i_START = 1'b0;
    check("edges", 32'(edges), 32'(W + nstall));
    check("done", 32'(bus.o_DONE), 32'd1);
    check("sum", 32'(bus.o_SUM), 32'(exp_sum));
    check("cout", 32'(bus.o_COUT), 32'(exp_cout));
    check("zero", 32'(bus.o_ZERO), 32'(exp_sum == '0));
    @(negedge clk);
    check("idle_done", 32'(bus.o_DONE), 32'd0);
    check("idle_busy", 32'(bus.o_BUSY), 32'd0);
    check("idle_sum", 32'(bus.o_SUM), 32'(exp_sum));
    check("idle_cout", 32'(bus.o_COUT), 32'(exp_cout));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(bus.o_SUM), 32'd0);
    check("rst_zero", 32'(bus.o_ZERO), 32'd1);
    check("rst_busy", 32'(bus.o_BUSY), 32'd0);
    check("rst_done", 32'(bus.o_DONE), 32'd0);
    check("rst_cout", 32'(bus.o_COUT), 32'd0);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h10, 8'h01, 1'b1, 0, 1'b0);
    do_op(8'h00, 8'h01, 1'b1, 0, 1'b0);
    do_op(8'h5A, 8'h3C, 1'b0, 3, 1'b0);
    do_op(8'h33, 8'h44, 1'b1, 0, 1'b1);

    // Reset in the middle of a run must clear everything immediately.
    do_load(8'h5A);
    bus.i_START = 1'b1;
    bus.i_SUB   = 1'b0;
    @(negedge clk);
    bus.i_START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_SER_B = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("mrst_sum", 32'(bus.o_SUM), 32'd0);
    check("mrst_zero", 32'(bus.o_ZERO), 32'd1);
    check("mrst_busy", 32'(bus.o_BUSY), 32'd0);
    check("mrst_done", 32'(bus.o_DONE), 32'd0);
    check("mrst_cout", 32'(bus.o_COUT), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h21, 8'h12, 1'b0, 1, 1'b0);

    // LOAD and START together: load wins, no run starts.
    @(negedge clk);
    bus.i_LOAD   = 1'b1;
    bus.i_START  = 1'b1;
    bus.i_LOAD_D = 8'hA5;
    @(negedge clk);
    bus.i_LOAD  = 1'b0;
    bus.i_START = 1'b0;
    check("ls_sum", 32'(bus.o_SUM), 32'hA5);
    check("ls_busy", 32'(bus.o_BUSY), 32'd0);
    @(negedge clk);
    check("ls_busy2", 32'(bus.o_BUSY), 32'd0);

    for (int t = 0; t < 25; t++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_acc_adder.md
# serial_acc_adder

Bit-serial add/subtract accumulator built around the single-bit full-adder primitive, used by the bubble-memory controller datapath for page/position arithmetic. It holds a WIDTH-bit accumulator, consumes a second operand one bit per enabled clock (LSB first), and retires the result in place. The carry between bit positions is kept in a flip-flop. The block sits directly downstream of the full-adder cell: it registers the cell's sum and carry outputs each bit time.

## Interface
- WIDTH, 8: accumulator and operand width in bits (2..32)
- i_EMUCLK  in  1  system clock, all state on rising edge
- i_MRST_n  in  1  asynchronous active-low master reset
- i_CEN_n  in  1  clock enable, active low; when high, all state holds
- i_LOAD  in  1  parallel load of accumulator (IDLE only)
- i_LOAD_D  in  WIDTH  parallel load value
- i_START  in  1  begin serial operation (IDLE only)
- i_SUB  in  1  0 = acc + B, 1 = acc − B; sampled with i_START
- i_SER_B  in  1  serial operand bit, LSB first, sampled during RUN
- o_BUSY  out  1  high in RUN
- o_DONE  out  1  high in DONE state
- o_SUM  out  WIDTH  accumulator contents
- o_COUT  out  1  final carry (subtract: 1 = no borrow)
- o_ZERO  out  1  o_SUM == 0

## Operation
- States: IDLE, RUN, DONE. Bit counter cnt, width clog2(WIDTH).
- All transitions occur only on edges where i_CEN_n = 0.
- IDLE + i_LOAD: acc ← i_LOAD_D, carry ← 0. Stay in IDLE.
- IDLE + i_START + !i_LOAD: sub_q ← i_SUB, carry ← i_SUB, cnt ← 0, go to RUN.
- IDLE + i_LOAD + i_START: load wins and START is dropped.
- RUN, each enabled edge:
  - Feed the adder cell with A = acc[0], B = i_SER_B ^ sub_q, CIN = carry.
  - acc ← {S, acc[WIDTH-1:1]}, carry ← COUT, cnt ← cnt + 1.
  - When cnt = WIDTH−1, go to DONE.
- DONE: outputs hold for one enabled cycle, then return to IDLE.
- i_LOAD and i_START outside IDLE are ignored.
- Arithmetic is modulo 2^WIDTH. Overflow is not flagged; only o_COUT is reported.
- o_COUT = carry register. It is meaningful in DONE and holds into IDLE until the next LOAD or START.
- i_MRST_n low at any time, including mid-RUN, forces:
  - state IDLE, acc = 0, carry = 0, cnt = 0, sub_q = 0.
  - Resulting outputs: o_SUM = 0, o_ZERO = 1, o_BUSY = 0, o_DONE = 0, o_COUT = 0.

## Timing
- START accepted at enabled edge k.
- i_SER_B bit n is sampled at enabled edge k+1+n, for n = 0..WIDTH−1.
- o_DONE rises after edge k+WIDTH and falls after edge k+WIDTH+1. Latency START→DONE is WIDTH enabled cycles.
- Disabled cycles (i_CEN_n = 1) stretch the sequence without changing the result. i_SER_B is not sampled on disabled edges.
- A new START may be accepted on the first enabled edge after returning to IDLE.
- o_SUM shows partially shifted values during RUN. It is valid only in DONE and IDLE.
- All outputs are direct register outputs or derived from registers; there is no combinational path from any input.

## Structure
- Shared controller package holds:
  - state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2)
  - default WIDTH constant for page-address arithmetic
- Single sub-module: the existing FA primitive, instantiated once. Its o_S and o_COUT are registered here.
- Remaining logic: state register, bit counter, accumulator shift register, carry and sub_q flops. Target roughly 150 lines.

## Test plan
- WIDTH=8, LOAD 0x5A, START add, serial 0x3C → o_DONE after 8 cycles, o_SUM = 0x96, o_COUT = 0, o_ZERO = 0.
- LOAD 0xFF, add 0x01 → o_SUM = 0x00, o_COUT = 1, o_ZERO = 1.
- LOAD 0x10, subtract 0x01 → o_SUM = 0x0F, o_COUT = 1. Then LOAD 0x00, subtract 0x01 → o_SUM = 0xFF, o_COUT = 0.
- Repeat the 0x5A + 0x3C case with i_CEN_n pulsed high for 3 random cycles mid-RUN, and i_SER_B toggled during the stalls → identical 0x96 result, o_DONE delayed by 3 cycles.
- Assert i_MRST_n low at bit 4 of a RUN → all outputs immediately take reset values. After release, a START is accepted normally.
- i_LOAD = 1 and i_START = 1 in the same cycle with i_LOAD_D = 0xA5 → acc = 0xA5, state stays IDLE, o_BUSY = 0. i_START during RUN → no restart, cycle count unchanged.
